// File: rtl/refill_buffer_mb_pkg.sv
// Shared types for the multi-beat refill buffer: entry state encoding, line id layout
// and a width helper used to size beat and entry indices.
package refill_buffer_mb_pkg;

   typedef enum logic [1:0] {
      RFB_FREE = 2'd0,
      RFB_FILL = 2'd1,
      RFB_DONE = 2'd2
   } rfbuf_state_e;

   localparam int RFB_SET_W = 6;
   localparam int RFB_WAY_W = 2;

   typedef struct packed {
      logic [RFB_WAY_W-1:0] way;
      logic [RFB_SET_W-1:0] set;
   } rfbuf_id_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/refill_buffer_mb_entry.sv
// One line slot of the refill buffer: holds the line id, a per-beat valid mask and the
// beat payloads, and reports id match, lookup hit and line completion to the top.
module refill_buffer_mb_entry
   import refill_buffer_mb_pkg::*;
#(
   parameter int ID_W   = 8,
   parameter int BEAT_W = 128,
   parameter int BEATS  = 4,
   parameter int BIDX_W = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    write,
   input  logic                    drain,
   input  logic [ID_W-1:0]         id,
   input  logic [BIDX_W-1:0]       beat,
   input  logic [BEAT_W-1:0]       data,
   input  logic                    lkp_valid,
   input  logic [ID_W-1:0]         lkp_id,
   input  logic [BIDX_W-1:0]       lkp_beat,
   output logic                    free,
   output logic                    match_fill,
   output logic                    match_done,
   output logic                    complete,
   output logic                    hit,
   output logic [BEAT_W-1:0]       hit_data,
   output logic [ID_W-1:0]         line_id,
   output logic [BEATS*BEAT_W-1:0] line_data
);

   rfbuf_state_e                  state;
   logic [ID_W-1:0]               id_q;
   logic [BEATS-1:0]              mask;
   logic [BEATS-1:0]              next_mask;
   logic [BEATS-1:0][BEAT_W-1:0]  mem;

   assign free       = (state == RFB_FREE);
   assign match_fill = (state == RFB_FILL) && (id_q == id);
   assign match_done = (state == RFB_DONE) && (id_q == id);

   // NOTE: always_comb uses blocking assignments and gives every output a default first,
   // so no path through the block can leave a value held and infer a latch.
   always_comb begin
      next_mask       = (state == RFB_FILL) ? mask : '0;
      next_mask[beat] = 1'b1;
   end

   assign complete  = write && (&next_mask);
   assign hit       = lkp_valid && !free && (id_q == lkp_id) && mask[lkp_beat];
   assign hit_data  = hit ? mem[lkp_beat] : '0;
   assign line_id   = id_q;
   assign line_data = mem;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RFB_FREE;
         mask  <= '0;
      end else if (drain) begin
         state <= RFB_FREE;
         mask  <= '0;
      end else if (write) begin
         mask  <= next_mask;
         state <= (&next_mask) ? RFB_DONE : RFB_FILL;
      end
   end

   // NOTE: id and payload storage carry no reset; state and mask gate every use of them.
   always_ff @(posedge clk) begin
      if (write) begin
         mem[beat] <= data;
         if (free) id_q <= id;
      end
   end

endmodule

// File: rtl/refill_buffer_mb.sv
// Multi-outstanding refill buffer: assembles beats into lines, forwards buffered beats to
// LSQ probes and drains completed lines to the data array in completion order.
module refill_buffer_mb
   import refill_buffer_mb_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int SET_W  = RFB_SET_W,
   parameter  int WAY_W  = RFB_WAY_W,
   parameter  int BEAT_W = 128,
   parameter  int BEATS  = 4,
   localparam int ID_W   = SET_W + WAY_W,
   localparam int BIDX_W = idx_width(BEATS),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    refill_valid,
   output logic                    refill_ready,
   input  logic [ID_W-1:0]         refill_id,
   input  logic [BIDX_W-1:0]       refill_beat,
   input  logic [BEAT_W-1:0]       refill_data,
   input  logic                    lkp_valid,
   input  logic [SET_W-1:0]        lkp_set,
   input  logic [WAY_W-1:0]        lkp_way,
   input  logic [BIDX_W-1:0]       lkp_beat,
   output logic                    lkp_hit,
   output logic [BEAT_W-1:0]       lkp_data,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [SET_W-1:0]        wr_set,
   output logic [WAY_W-1:0]        wr_way,
   output logic [BEAT_W*BEATS-1:0] wr_data,
   output logic [CNT_W-1:0]        occupancy
);

   localparam int IDX_W = idx_width(DEPTH);

   logic [DEPTH-1:0]         free, match_fill, match_done, complete, hit, write, drain;
   logic [DEPTH-1:0]         alloc_sel;
   logic [BEAT_W-1:0]        hit_data  [DEPTH];
   logic [ID_W-1:0]          line_id   [DEPTH];
   logic [BEATS*BEAT_W-1:0]  line_data [DEPTH];
   logic [ID_W-1:0]          lkp_id;
   logic                     any_match, accept, alloc, push, pop;
   logic [IDX_W-1:0]         push_idx, head;

   logic [IDX_W-1:0]         dq [DEPTH];
   logic [IDX_W-1:0]         q_head, q_tail;
   logic                     q_head_wrap, q_tail_wrap;

   assign lkp_id = {lkp_way, lkp_set};

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      refill_buffer_mb_entry #(
         .ID_W   (ID_W),
         .BEAT_W (BEAT_W),
         .BEATS  (BEATS),
         .BIDX_W (BIDX_W)
      ) u_entry (
         .clk        (clk),
         .rst        (rst),
         .write      (write[i]),
         .drain      (drain[i]),
         .id         (refill_id),
         .beat       (refill_beat),
         .data       (refill_data),
         .lkp_valid  (lkp_valid),
         .lkp_id     (lkp_id),
         .lkp_beat   (lkp_beat),
         .free       (free[i]),
         .match_fill (match_fill[i]),
         .match_done (match_done[i]),
         .complete   (complete[i]),
         .hit        (hit[i]),
         .hit_data   (hit_data[i]),
         .line_id    (line_id[i]),
         .line_data  (line_data[i])
      );
   end

   // Lowest set bit of the FREE vector picks the allocation target.
   assign alloc_sel    = free & (~free + DEPTH'(1));
   assign any_match    = |(match_fill | match_done);
   assign refill_ready = (|match_fill) || (!any_match && (|free));
   assign accept       = refill_valid && refill_ready;
   assign alloc        = accept && !(|match_fill);
   assign write        = {DEPTH{accept}} & (match_fill | ({DEPTH{alloc}} & alloc_sel));

   // Only one entry is written per cycle, so at most one completion needs encoding.
   assign push = |complete;
   always_comb begin
      push_idx = '0;
      for (int i = 0; i < DEPTH; i++)
         if (complete[i]) push_idx = IDX_W'(i);
   end

   assign head     = dq[q_head];
   assign wr_valid = !((q_head == q_tail) && (q_head_wrap == q_tail_wrap));
   assign pop      = wr_valid && wr_ready;
   assign drain    = pop ? (DEPTH'(1) << head) : '0;

   always_comb begin
      wr_set  = '0;
      wr_way  = '0;
      wr_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (head == IDX_W'(i)) begin
            {wr_way, wr_set} = line_id[i];
            wr_data          = line_data[i];
         end
      end
   end

   assign lkp_hit = |hit;
   always_comb begin
      lkp_data = '0;
      for (int i = 0; i < DEPTH; i++) lkp_data = lkp_data | hit_data[i];
   end

   // Pointers wrap at DEPTH-1 and toggle a lap bit, so DEPTH need not be a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_head      <= '0;
         q_tail      <= '0;
         q_head_wrap <= 1'b0;
         q_tail_wrap <= 1'b0;
         occupancy   <= '0;
      end else begin
         if (push) begin
            if (q_tail == IDX_W'(DEPTH - 1)) begin
               q_tail      <= '0;
               q_tail_wrap <= ~q_tail_wrap;
            end else begin
               q_tail <= q_tail + IDX_W'(1);
            end
         end
         if (pop) begin
            if (q_head == IDX_W'(DEPTH - 1)) begin
               q_head      <= '0;
               q_head_wrap <= ~q_head_wrap;
            end else begin
               q_head <= q_head + IDX_W'(1);
            end
         end
         occupancy <= occupancy + CNT_W'(alloc) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) dq[q_tail] <= push_idx;
   end

endmodule

// File: tb/tb_refill_buffer_mb.sv
// Directed bench for refill_buffer_mb: stimulus pushes expected drained lines into a
// scoreboard queue, a negedge monitor pops and compares on every write handshake.
module tb_refill_buffer_mb;
   import refill_buffer_mb_pkg::*;

   localparam int DEPTH  = 4;
   localparam int SET_W  = 6;
   localparam int WAY_W  = 2;
   localparam int BEAT_W = 128;
   localparam int BEATS  = 4;
   localparam int ID_W   = SET_W + WAY_W;
   localparam int BIDX_W = 2;
   localparam int CNT_W  = 3;
   localparam int LINE_W = BEAT_W * BEATS;
   localparam int CHK_W  = 1 + ID_W + LINE_W;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 refill_valid, refill_ready;
   logic [ID_W-1:0]      refill_id;
   logic [BIDX_W-1:0]    refill_beat;
   logic [BEAT_W-1:0]    refill_data;
   logic                 lkp_valid, lkp_hit;
   logic [SET_W-1:0]     lkp_set;
   logic [WAY_W-1:0]     lkp_way;
   logic [BIDX_W-1:0]    lkp_beat;
   logic [BEAT_W-1:0]    lkp_data;
   logic                 wr_valid, wr_ready;
   logic [SET_W-1:0]     wr_set;
   logic [WAY_W-1:0]     wr_way;
   logic [LINE_W-1:0]    wr_data;
   logic [CNT_W-1:0]     occupancy;

   always #5 clk = ~clk;

   refill_buffer_mb #(
      .DEPTH (DEPTH), .SET_W (SET_W), .WAY_W (WAY_W), .BEAT_W (BEAT_W), .BEATS (BEATS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .refill_valid (refill_valid),
      .refill_ready (refill_ready),
      .refill_id    (refill_id),
      .refill_beat  (refill_beat),
      .refill_data  (refill_data),
      .lkp_valid    (lkp_valid),
      .lkp_set      (lkp_set),
      .lkp_way      (lkp_way),
      .lkp_beat     (lkp_beat),
      .lkp_hit      (lkp_hit),
      .lkp_data     (lkp_data),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_set       (wr_set),
      .wr_way       (wr_way),
      .wr_data      (wr_data),
      .occupancy    (occupancy)
   );

   int n_pass  = 0;
   int n_total = 0;
   logic [CHK_W-1:0] exp_q [$];

   task automatic check(input string name, input logic [CHK_W-1:0] act, input logic [CHK_W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   function automatic rfbuf_id_t mk(input int way, input int set);
      return rfbuf_id_t'{way: WAY_W'(way), set: SET_W'(set)};
   endfunction

   // Beat payload tagged with id, beat index and a salt so overwrites are distinguishable.
   function automatic logic [BEAT_W-1:0] bd(input rfbuf_id_t id, input int b, input int salt);
      return {id, 8'(b), 8'(salt), 16'hBEEF, 88'(32'hC0DE0000 + (int'(id) << 4) + b)};
   endfunction

   function automatic logic [CHK_W-1:0] exp_line(input rfbuf_id_t id);
      return {1'b0, id, bd(id, 3, 0), bd(id, 2, 0), bd(id, 1, 0), bd(id, 0, 0)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input rfbuf_id_t id, input int b, input int salt);
      int n = 0;
      refill_valid = 1'b1;
      refill_id    = id;
      refill_beat  = BIDX_W'(b);
      refill_data  = bd(id, b, salt);
      @(negedge clk);
      while (!refill_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!refill_ready) begin
         n_total++;
         $display("FAIL send_timeout: id %0h beat %0d never accepted", id, b);
      end
      cyc();
      refill_valid = 1'b0;
   endtask

   task automatic probe(input string name, input rfbuf_id_t id, input int b,
                        input logic exp_hit, input logic [BEAT_W-1:0] exp_data);
      lkp_valid = 1'b1;
      lkp_set   = id.set;
      lkp_way   = id.way;
      lkp_beat  = BIDX_W'(b);
      #1;
      check({name, "_hit"}, lkp_hit, exp_hit);
      check({name, "_data"}, lkp_data, exp_data);
   endtask

   // Handshake completes on the following posedge; compare what is presented now.
   always @(negedge clk) begin
      if (!rst && wr_valid && wr_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL wr_unexpected: got set %0h way %0h, want no write", wr_set, wr_way);
         end else begin
            check("wr_line", {1'b0, wr_way, wr_set, wr_data}, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rfbuf_id_t a, b, c, i4, a2, b2;
      rfbuf_id_t ids [4];
      rfbuf_id_t rids [3];

      rst = 1'b1; refill_valid = 1'b0; refill_id = '0; refill_beat = '0; refill_data = '0;
      lkp_valid = 1'b0; lkp_set = '0; lkp_way = '0; lkp_beat = '0; wr_ready = 1'b0;
      repeat (2) cyc();
      rst = 1'b0;
      lkp_valid = 1'b1;
      #1;
      check("rst_occ", occupancy, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_lkp_hit", lkp_hit, 0);
      check("rst_lkp_data", lkp_data, 0);
      check("rst_ready", refill_ready, 1);
      cyc();

      // In-order line, with a duplicate of beat 0 that must be overwritten.
      a = mk(1, 5);
      wr_ready = 1'b1;
      send_beat(a, 0, 7);
      send_beat(a, 0, 0);
      send_beat(a, 1, 0);
      send_beat(a, 2, 0);
      check("t1_wr_valid_early", wr_valid, 0);
      check("t1_occ", occupancy, 1);
      exp_q.push_back(exp_line(a));
      send_beat(a, 3, 0);
      check("t1_wr_valid", wr_valid, 1);
      cyc();
      check("t1_drained", wr_valid, 0);
      check("t1_occ_drained", occupancy, 0);

      // Out-of-order beats, forwarding visibility, DONE id blocking.
      b = mk(2, 17);
      c = mk(3, 33);
      wr_ready = 1'b0;
      probe("t2_pre", b, 2, 1'b0, '0);
      send_beat(b, 2, 0);
      probe("t2_b2", b, 2, 1'b1, bd(b, 2, 0));
      probe("t2_b1_miss", b, 1, 1'b0, '0);
      send_beat(b, 0, 0);
      send_beat(b, 3, 0);
      probe("t2_b1_still_miss", b, 1, 1'b0, '0);
      exp_q.push_back(exp_line(b));
      send_beat(b, 1, 0);
      probe("t2_done_visible", b, 1, 1'b1, bd(b, 1, 0));
      refill_id = b;
      #1;
      check("t2_done_blocks", refill_ready, 0);
      check("t2_wr_valid", wr_valid, 1);
      check("t2_occ", occupancy, 1);
      refill_id = c;
      #1;
      check("t2_other_ready", refill_ready, 1);
      cyc();
      wr_ready = 1'b1;
      cyc();
      probe("t2_after_drain", b, 1, 1'b0, '0);
      check("t2_occ_drained", occupancy, 0);
      refill_id = b;
      #1;
      check("t2_reuse_ready", refill_ready, 1);
      exp_q.push_back(exp_line(b));
      for (int k = 0; k < BEATS; k++) send_beat(b, k, 0);
      cyc();
      check("t2_refill_drained", wr_valid, 0);
      check("t2_refill_occ", occupancy, 0);

      // Four interleaved lines fill the buffer; a fifth id waits for the first drain.
      for (int k = 0; k < 4; k++) ids[k] = mk(k, 40 + k);
      i4 = mk(3, 63);
      wr_ready = 1'b0;
      for (int bt = 0; bt < 3; bt++)
         for (int k = 0; k < 4; k++) send_beat(ids[k], bt, 0);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(exp_line(ids[k]));
         send_beat(ids[k], 3, 0);
      end
      check("t3_occ_full", occupancy, 4);
      refill_valid = 1'b1;
      refill_id    = i4;
      refill_beat  = '0;
      refill_data  = bd(i4, 0, 0);
      #1;
      check("t3_full", refill_ready, 0);
      cyc();
      cyc();
      check("t3_full_hold", refill_ready, 0);
      check("t3_occ_hold", occupancy, 4);
      wr_ready = 1'b1;
      #1;
      check("t3_before_handshake", refill_ready, 0);
      cyc();
      check("t3_after_handshake", refill_ready, 1);
      check("t3_occ_after_drain", occupancy, 3);
      cyc();
      refill_valid = 1'b0;
      check("t3_alloc_and_drain", occupancy, 3);
      cyc();
      check("t3_occ_2", occupancy, 2);
      cyc();
      check("t3_occ_1", occupancy, 1);
      exp_q.push_back(exp_line(i4));
      for (int k = 1; k < BEATS; k++) send_beat(i4, k, 0);
      cyc();
      check("t3_occ_empty", occupancy, 0);
      check("t3_wr_idle", wr_valid, 0);

      // B completes before A; output held stable under backpressure, then B, then A.
      a2 = mk(0, 9);
      b2 = mk(1, 10);
      wr_ready = 1'b0;
      send_beat(a2, 0, 0);
      for (int k = 0; k < 3; k++) send_beat(b2, k, 0);
      exp_q.push_back(exp_line(b2));
      send_beat(b2, 3, 0);
      exp_q.push_back(exp_line(a2));
      for (int k = 1; k < BEATS; k++) send_beat(a2, k, 0);
      for (int k = 0; k < 10; k++) begin
         check("t4_hold", {wr_valid, wr_way, wr_set, wr_data}, exp_line(b2) | {1'b1, {(CHK_W-1){1'b0}}});
         cyc();
      end
      wr_ready = 1'b1;
      repeat (3) cyc();
      check("t4_wr_idle", wr_valid, 0);
      check("t4_occ", occupancy, 0);

      // Reset in the middle of three partial lines discards them.
      for (int k = 0; k < 3; k++) rids[k] = mk(2, k + 1);
      for (int bt = 0; bt < 2; bt++)
         for (int k = 0; k < 3; k++) send_beat(rids[k], bt, 0);
      check("t6_occ_pre", occupancy, 3);
      probe("t6_pre", rids[0], 1, 1'b1, bd(rids[0], 1, 0));
      refill_id = rids[0];
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("t6_occ", occupancy, 0);
      check("t6_wr_valid", wr_valid, 0);
      check("t6_lkp_hit", lkp_hit, 0);
      check("t6_lkp_data", lkp_data, 0);
      check("t6_ready", refill_ready, 1);
      cyc();

      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
